// File: rtl/mips_pkg.sv
// Shared types and constants for the HI/LO multiply/divide controller.
package mips_pkg;

    localparam int MD_DATA_WIDTH = 32;
    localparam int MD_LATENCY    = MD_DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIN  = 2'b10
    } md_state_t;

    // Divide ops live in the upper half of the encoding.
    function automatic logic md_is_div(input md_op_t op);
        return op[1];
    endfunction

    // Signed ops have a zero in the low encoding bit.
    function automatic logic md_is_signed(input md_op_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Decoder <-> multiply/divide sequencer handshake and result bus.
interface muldiv_sequencer_if
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    md_op_t                op;
    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] operand_b;
    logic                  abort;
    logic                  busy;
    logic                  stall_req;
    logic                  done;
    logic                  hi_write;
    logic                  lo_write;
    logic [DATA_WIDTH-1:0] hi_out;
    logic [DATA_WIDTH-1:0] lo_out;
    logic                  div_zero;

    // Decoder side: issues operations, observes results.
    modport master (
        output start, op, operand_a, operand_b, abort,
        input  busy, stall_req, done, hi_write, lo_write, hi_out, lo_out, div_zero
    );

    // Sequencer side.
    modport slave (
        input  start, op, operand_a, operand_b, abort,
        output busy, stall_req, done, hi_write, lo_write, hi_out, lo_out, div_zero
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared engine: shift-add multiply or restoring divide.
// Multiply: {acc,q} holds partial product / remaining multiplier, shifts right.
// Divide:   {acc,q} holds partial remainder / dividend-then-quotient, shifts left.
module muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_is_div,
    input  logic [DATA_WIDTH-1:0] i_acc,
    input  logic [DATA_WIDTH-1:0] i_q,
    input  logic [DATA_WIDTH-1:0] i_m,
    output logic [DATA_WIDTH-1:0] o_acc,
    output logic [DATA_WIDTH-1:0] o_q
);
    logic [DATA_WIDTH:0] w_addend;
    logic [DATA_WIDTH:0] w_sum;
    logic [DATA_WIDTH:0] w_shift;
    logic [DATA_WIDTH:0] w_diff;

    // Partial remainder is always below the divisor, so the shifted value
    // fits in DATA_WIDTH+1 bits and the diff MSB is a clean borrow flag.
    assign w_addend = i_q[0] ? {1'b0, i_m} : {(DATA_WIDTH+1){1'b0}};
    assign w_sum    = {1'b0, i_acc} + w_addend;
    assign w_shift  = {i_acc, i_q[DATA_WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, i_m};

    // Select the multiply or divide iteration result.
    always_comb begin
        o_acc = i_acc;
        o_q   = i_q;
        if (i_is_div) begin
            if (!w_diff[DATA_WIDTH]) begin
                o_acc = w_diff[DATA_WIDTH-1:0];
                o_q   = {i_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                o_acc = w_shift[DATA_WIDTH-1:0];
                o_q   = {i_q[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            o_acc = w_sum[DATA_WIDTH:1];
            o_q   = {w_sum[0], i_q[DATA_WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO multiply/divide controller: sequences the shared
// iterative engine, holds the pipeline while busy, strobes HI/LO writes.
module muldiv_sequencer
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_sequencer_if.slave md
);
    md_state_t               r_state;
    md_op_t                  r_op;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0]   r_acc;
    logic [DATA_WIDTH-1:0]   r_q;
    logic [DATA_WIDTH-1:0]   r_m;
    logic [DATA_WIDTH-1:0]   r_raw_a;
    logic                    r_neg_q;
    logic                    r_neg_r;
    logic                    r_div0;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_div_zero;
    logic [DATA_WIDTH-1:0]   r_hi;
    logic [DATA_WIDTH-1:0]   r_lo;

    logic                    w_start_div;
    logic                    w_a_neg;
    logic                    w_b_neg;
    logic [DATA_WIDTH-1:0]   w_abs_a;
    logic [DATA_WIDTH-1:0]   w_abs_b;
    logic [DATA_WIDTH-1:0]   w_acc_nxt;
    logic [DATA_WIDTH-1:0]   w_q_nxt;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [2*DATA_WIDTH-1:0] w_prod_fix;
    logic [DATA_WIDTH-1:0]   w_quo_fix;
    logic [DATA_WIDTH-1:0]   w_rem_fix;

    // Two's-complement negate when the flag is set.
    function automatic logic [DATA_WIDTH-1:0] neg_if(input logic [DATA_WIDTH-1:0] v,
                                                      input logic                  neg);
        return neg ? ({DATA_WIDTH{1'b0}} - v) : v;
    endfunction

    // Magnitudes are taken as unsigned, so |0x80000000| is exactly 2^31.
    assign w_start_div = md_is_div(md.op);
    assign w_a_neg     = md_is_signed(md.op) & md.operand_a[DATA_WIDTH-1];
    assign w_b_neg     = md_is_signed(md.op) & md.operand_b[DATA_WIDTH-1];
    assign w_abs_a     = neg_if(md.operand_a, w_a_neg);
    assign w_abs_b     = neg_if(md.operand_b, w_b_neg);

    muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .i_is_div (md_is_div(r_op)),
        .i_acc    (r_acc),
        .i_q      (r_q),
        .i_m      (r_m),
        .o_acc    (w_acc_nxt),
        .o_q      (w_q_nxt)
    );

    // Sign correction applied to the final iteration's output.
    assign w_prod     = {w_acc_nxt, w_q_nxt};
    assign w_prod_fix = r_neg_q ? ({(2*DATA_WIDTH){1'b0}} - w_prod) : w_prod;
    assign w_quo_fix  = neg_if(w_q_nxt, r_neg_q);
    assign w_rem_fix  = neg_if(w_acc_nxt, r_neg_r);

    // Controller FSM, iteration counter and registered result outputs.
    // Results are registered on the last RUN edge so done lines up with FIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= MD_IDLE;
            r_op       <= MD_MULT;
            r_cnt      <= {CNT_WIDTH{1'b0}};
            r_acc      <= {DATA_WIDTH{1'b0}};
            r_q        <= {DATA_WIDTH{1'b0}};
            r_m        <= {DATA_WIDTH{1'b0}};
            r_raw_a    <= {DATA_WIDTH{1'b0}};
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= {DATA_WIDTH{1'b0}};
            r_lo       <= {DATA_WIDTH{1'b0}};
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    if (md.start && !md.abort) begin
                        r_op    <= md.op;
                        r_acc   <= {DATA_WIDTH{1'b0}};
                        r_q     <= w_start_div ? w_abs_a : w_abs_b;
                        r_m     <= w_start_div ? w_abs_b : w_abs_a;
                        r_raw_a <= md.operand_a;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_div0  <= w_start_div & (md.operand_b == {DATA_WIDTH{1'b0}});
                        r_cnt   <= CNT_WIDTH'(DATA_WIDTH - 1);
                        r_busy  <= 1'b1;
                        r_state <= MD_RUN;
                    end
                end
                MD_RUN: begin
                    if (md.abort) begin
                        r_busy  <= 1'b0;
                        r_state <= MD_IDLE;
                    end else begin
                        r_acc <= w_acc_nxt;
                        r_q   <= w_q_nxt;
                        if (r_cnt == {CNT_WIDTH{1'b0}}) begin
                            if (r_div0) begin
                                r_hi <= r_raw_a;
                                r_lo <= {DATA_WIDTH{1'b1}};
                            end else if (md_is_div(r_op)) begin
                                r_hi <= w_rem_fix;
                                r_lo <= w_quo_fix;
                            end else begin
                                r_hi <= w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
                                r_lo <= w_prod_fix[DATA_WIDTH-1:0];
                            end
                            r_done     <= 1'b1;
                            r_div_zero <= r_div0;
                            r_state    <= MD_FIN;
                        end else begin
                            r_cnt <= r_cnt - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                end
                MD_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= MD_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= MD_IDLE;
                end
            endcase
        end
    end

    assign md.busy      = r_busy;
    assign md.done      = r_done;
    assign md.hi_write  = r_done;
    assign md.lo_write  = r_done;
    assign md.hi_out    = r_hi;
    assign md.lo_out    = r_lo;
    assign md.div_zero  = r_div_zero;
    assign md.stall_req = (md.start && (r_state == MD_IDLE)) || r_busy;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer.
module tb_muldiv_sequencer;
    import mips_pkg::*;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    muldiv_sequencer_if #(.DATA_WIDTH(32)) md ();

    muldiv_sequencer #(.DATA_WIDTH(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op and follow it to completion, abort, or timeout.
    task automatic run_op(input string tag, input md_op_t op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz, input int abort_cyc, input int restart_cyc);
        int          done_cyc;
        int          busy_cnt;
        int          extra;
        logic [31:0] got_hi;
        logic [31:0] got_lo;
        logic        got_dz;
        logic        got_hw;
        logic        got_lw;
        done_cyc = 0; busy_cnt = 0; extra = 0;
        got_hi = 32'h0; got_lo = 32'h0; got_dz = 1'b0; got_hw = 1'b0; got_lw = 1'b0;
        @(negedge clk);
        md.start = 1'b1; md.op = op; md.operand_a = a; md.operand_b = b;
        #1 check({tag, ":stall_on_start"}, 64'(md.stall_req), 64'd1);
        @(posedge clk);
        #1;
        md.start = 1'b0; md.op = MD_DIVU;
        md.operand_a = 32'hDEAD_BEEF; md.operand_b = 32'h0000_0000;
        for (int cyc = 1; cyc <= 60 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            md.start = 1'b0;
            if (md.busy) busy_cnt++;
            if (md.done) begin
                done_cyc = cyc;
                got_hi = md.hi_out; got_lo = md.lo_out; got_dz = md.div_zero;
                got_hw = md.hi_write; got_lw = md.lo_write;
            end
            if (cyc == abort_cyc) begin
                md.abort = 1'b1;
                break;
            end
            if (cyc == restart_cyc) begin
                md.start = 1'b1; md.op = MD_MULTU;
                md.operand_a = 32'd9; md.operand_b = 32'd9;
            end
        end
        if (abort_cyc != 0) begin
            check({tag, ":no_done_before_abort"}, 64'(done_cyc), 64'd0);
            @(negedge clk);
            md.abort = 1'b0;
            check({tag, ":busy_after_abort"}, 64'(md.busy), 64'd0);
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (md.done || md.hi_write || md.lo_write) extra++;
            end
            check({tag, ":no_strobe_after_abort"}, 64'(extra), 64'd0);
            check({tag, ":hi_retained"}, 64'(md.hi_out), 64'(exp_hi));
            check({tag, ":lo_retained"}, 64'(md.lo_out), 64'(exp_lo));
        end else begin
            check({tag, ":latency"}, 64'(done_cyc), 64'd33);
            check({tag, ":busy_cycles"}, 64'(busy_cnt), 64'd33);
            check({tag, ":hi"}, 64'(got_hi), 64'(exp_hi));
            check({tag, ":lo"}, 64'(got_lo), 64'(exp_lo));
            check({tag, ":div_zero"}, 64'(got_dz), 64'(exp_dz));
            check({tag, ":hi_write"}, 64'(got_hw), 64'd1);
            check({tag, ":lo_write"}, 64'(got_lw), 64'd1);
            @(negedge clk);
            check({tag, ":done_one_cycle"}, 64'(md.done), 64'd0);
            check({tag, ":dz_one_cycle"}, 64'(md.div_zero), 64'd0);
            check({tag, ":idle_after"}, 64'(md.busy), 64'd0);
            if (restart_cyc != 0) begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (md.done || md.busy) extra++;
                end
                check({tag, ":restart_ignored"}, 64'(extra), 64'd0);
                check({tag, ":lo_after_restart"}, 64'(md.lo_out), 64'(exp_lo));
            end
        end
    endtask

    initial begin
        int extra;
        tests_run = 0; tests_failed = 0; extra = 0;
        rst_n = 1'b0;
        md.start = 1'b0; md.abort = 1'b0; md.op = MD_MULT;
        md.operand_a = 32'h0; md.operand_b = 32'h0;
        repeat (3) @(negedge clk);
        check("rst:busy", 64'(md.busy), 64'd0);
        check("rst:done", 64'(md.done), 64'd0);
        check("rst:hi", 64'(md.hi_out), 64'd0);
        check("rst:lo", 64'(md.lo_out), 64'd0);
        check("rst:dz", 64'(md.div_zero), 64'd0);
        check("rst:stall", 64'(md.stall_req), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 0);
        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd7,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, 0);
        run_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 0);
        run_op("div_wrap", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000, 1'b0, 0, 0);
        run_op("divu_100_0", MD_DIVU, 32'd100, 32'd0,
               32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 0, 0);
        run_op("div_m5_0", MD_DIV, 32'hFFFF_FFFB, 32'd0,
               32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 0, 0);
        run_op("divu_big", MD_DIVU, 32'hFFFF_FFFF, 32'd10,
               32'h0000_0005, 32'h1999_9999, 1'b0, 0, 0);
        run_op("multu_5x6", MD_MULTU, 32'd5, 32'd6,
               32'h0000_0000, 32'd30, 1'b0, 0, 0);
        run_op("mult_abort", MD_MULT, 32'd3, 32'd4,
               32'h0000_0000, 32'd30, 1'b0, 10, 0);

        // Start together with abort in IDLE must not be accepted.
        @(negedge clk);
        md.start = 1'b1; md.abort = 1'b1; md.op = MD_MULTU;
        md.operand_a = 32'd2; md.operand_b = 32'd2;
        @(negedge clk);
        md.start = 1'b0; md.abort = 1'b0;
        check("abort_start:busy", 64'(md.busy), 64'd0);

        run_op("multu_restart", MD_MULTU, 32'd2, 32'd3,
               32'h0000_0000, 32'd6, 1'b0, 0, 5);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        md.start = 1'b1; md.op = MD_DIV; md.operand_a = 32'd100; md.operand_b = 32'd7;
        @(negedge clk);
        md.start = 1'b0;
        repeat (14) @(negedge clk);
        check("rstmid:busy_before", 64'(md.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid:busy", 64'(md.busy), 64'd0);
        check("rstmid:done", 64'(md.done), 64'd0);
        check("rstmid:hi", 64'(md.hi_out), 64'd0);
        check("rstmid:lo", 64'(md.lo_out), 64'd0);
        check("rstmid:stall", 64'(md.stall_req), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (md.done || md.busy) extra++;
        end
        check("rstmid:no_done_after", 64'(extra), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
